// File: rtl/rdback_serializer.sv
// ----------------------------------------------------------------------------
// rdback_serializer
//
// Drains the readback FIFO written by the DFI read-capture stage. Each read
// word is 4*DQ_WIDTH bits wide. The block cuts each word into NUM_CHUNKS beats
// of OUT_WIDTH bits and sends them to the host-link transmit path over a
// valid/ready handshake. The lowest chunk is sent first.
//
// Input side: standard (non-FWFT) FIFO read protocol. rdback_fifo_rddata is
// valid in the cycle after the rdback_fifo_rden pulse.
//
// Output side: out_valid / out_ready / out_data / out_last. out_last marks the
// final beat of each word. rdback_word_cnt counts fully transmitted words and
// wraps at 2^32.
//
// Build option:
//   RDBACK_BYTE_SWAP_EN - when defined, the bytes inside each output beat are
//                         reversed for the little-endian host path. Control
//                         timing is the same in both builds.
//
// Parameter constraints:
//   4*DQ_WIDTH must be an integer multiple (>= 2) of OUT_WIDTH.
//   OUT_WIDTH must be a multiple of 8.
// ----------------------------------------------------------------------------
module rdback_serializer #(
    parameter int DQ_WIDTH  = 64,
    parameter int OUT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdback_fifo_empty,
    input  logic [4*DQ_WIDTH-1:0]   rdback_fifo_rddata,
    output logic                    rdback_fifo_rden,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_last,
    output logic [31:0]             rdback_word_cnt
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int WORD_W     = 4 * DQ_WIDTH;
    localparam int NUM_CHUNKS = WORD_W / OUT_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int BEAT_BYTES = OUT_WIDTH / 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    // ------------------------------------------------------------------------
    // Sequencer states
    //   IDLE  : waiting for the FIFO to hold a word
    //   FETCH : FIFO read data is on the bus this cycle; capture it
    //   SEND  : present the captured word one beat at a time
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------

    // Pick chunk idx out of a full read word. This is written as an AND-OR
    // mux so that the index never drives a variable part-select directly.
    function automatic logic [OUT_WIDTH-1:0] select_chunk(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  idx
    );
        logic [OUT_WIDTH-1:0] chunk;
        chunk = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            chunk = chunk | (word[i*OUT_WIDTH +: OUT_WIDTH] &
                             {OUT_WIDTH{idx == IDX_W'(i)}});
        end
        return chunk;
    endfunction

    // Put a chunk into host byte order. The swap build reverses the bytes
    // inside the beat (byte 0 <-> byte BEAT_BYTES-1). The default build sends
    // the chunk unchanged.
    function automatic logic [OUT_WIDTH-1:0] format_beat(
        input logic [OUT_WIDTH-1:0] chunk
    );
        logic [OUT_WIDTH-1:0] beat;
`ifdef RDBACK_BYTE_SWAP_EN
        beat = '0;
        for (int b = 0; b < BEAT_BYTES; b++) begin
            beat[b*8 +: 8] = chunk[(BEAT_BYTES-1-b)*8 +: 8];
        end
`else
        beat = chunk;
`endif
        return beat;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                 state_q,     state_d;
    logic [IDX_W-1:0]       chunk_idx_q, chunk_idx_d;
    logic [WORD_W-1:0]      buffer_q,    buffer_d;
    logic [31:0]            word_cnt_q,  word_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q,  out_last_d;
    logic [OUT_WIDTH-1:0]   out_data_q,  out_data_d;

    logic                   rden_s;
    logic                   handshake_s;
    logic                   last_beat_s;
    logic [IDX_W-1:0]       next_idx_s;

    // Next-state, next-output and FIFO read strobe for the sequencer
    always_comb begin
        state_d     = state_q;
        chunk_idx_d = chunk_idx_q;
        buffer_d    = buffer_q;
        word_cnt_d  = word_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        rden_s      = 1'b0;

        handshake_s = out_valid_q & out_ready;
        last_beat_s = (chunk_idx_q == LAST_IDX);
        next_idx_s  = chunk_idx_q + IDX_W'(1);

        case (state_q)
            ST_IDLE: begin
                // A word waiting in IDLE is requested in the same cycle.
                if (!rdback_fifo_empty) begin
                    rden_s  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                // The read data arrives this cycle. Capture the whole word
                // and load beat 0 directly into the output register, so the
                // first beat is valid on the next cycle.
                buffer_d    = rdback_fifo_rddata;
                chunk_idx_d = '0;
                out_valid_d = 1'b1;
                out_data_d  = format_beat(select_chunk(rdback_fifo_rddata, '0));
                // A word always has at least two chunks, so beat 0 is never
                // the last beat.
                out_last_d  = 1'b0;
                state_d     = ST_SEND;
            end

            ST_SEND: begin
                if (handshake_s) begin
                    if (last_beat_s) begin
                        // The word is finished. Count it. Then either chain
                        // straight into the next word, or go back to IDLE.
                        word_cnt_d  = word_cnt_q + 32'd1;
                        chunk_idx_d = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        if (!rdback_fifo_empty) begin
                            rden_s  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        chunk_idx_d = next_idx_s;
                        out_data_d  = format_beat(select_chunk(buffer_q, next_idx_s));
                        out_last_d  = (next_idx_s == LAST_IDX);
                        state_d     = ST_SEND;
                    end
                end else begin
                    // Stalled. Every output holds its value until the beat
                    // is accepted.
                    state_d = ST_SEND;
                end
            end

            default: begin
                // An illegal state code recovers to a clean IDLE.
                state_d     = ST_IDLE;
                chunk_idx_d = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_data_d  = '0;
            end
        endcase
    end

    // Sequencer state, beat index, word buffer, word counter and output
    // registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            chunk_idx_q <= '0;
            buffer_q    <= '0;
            word_cnt_q  <= 32'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            chunk_idx_q <= chunk_idx_d;
            buffer_q    <= buffer_d;
            word_cnt_q  <= word_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Output drive. The read strobe is combinational, so a waiting word is
    // requested in the same cycle. It is qualified by rst_n so that no strobe
    // reaches the FIFO while the block is held in reset.
    always_comb begin
        rdback_fifo_rden = rden_s & rst_n;
        out_valid        = out_valid_q;
        out_last         = out_last_q;
        out_data         = out_data_q;
        rdback_word_cnt  = word_cnt_q;
    end

endmodule

// File: tb/tb_rdback_serializer.sv
// ----------------------------------------------------------------------------
// tb_rdback_serializer
//
// Self-checking bench for rdback_serializer (DQ_WIDTH = 64, OUT_WIDTH = 32).
// A non-FWFT FIFO model feeds the DUT. A word-level scoreboard predicts the
// beat stream: every word popped from the FIFO adds its 8 chunks, in host
// byte order, to the expected queue.
// Define RDBACK_BYTE_SWAP_EN for both the bench and the RTL to check the
// byte-swapped build.
// ----------------------------------------------------------------------------
module tb_rdback_serializer;

    localparam int DQ_WIDTH  = 64;
    localparam int OUT_WIDTH = 32;
    localparam int NC        = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rdback_fifo_empty;
    logic [255:0]   rdback_fifo_rddata;
    logic           rdback_fifo_rden;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_data;
    logic           out_last;
    logic [31:0]    rdback_word_cnt;

    always #5 clk = ~clk;

    rdback_serializer #(.DQ_WIDTH(DQ_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rdback_fifo_empty  (rdback_fifo_empty),
        .rdback_fifo_rddata (rdback_fifo_rddata),
        .rdback_fifo_rden   (rdback_fifo_rden),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_last           (out_last),
        .rdback_word_cnt    (rdback_word_cnt)
    );

    typedef struct {
        logic [255:0] word;
        logic [31:0]  exp_first;
        logic [31:0]  exp_last;
    } vec_t;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [255:0]   fifo_q[$];
    logic [31:0]    exp_beats[$];
    logic [31:0]    got_q[$];
    int             beat_in_word = 0;
    logic [31:0]    model_words  = 32'd0;
    int             cyc = 0;
    bit             rden_log  [0:63];
    bit             valid_log [0:63];
    logic           prev_stall = 1'b0;
    logic [31:0]    prev_data  = 32'd0;
    logic           prev_last  = 1'b0;

    function automatic logic [31:0] host_beat(input logic [31:0] c);
`ifdef RDBACK_BYTE_SWAP_EN
        return {c[7:0], c[15:8], c[23:16], c[31:24]};
`else
        return c;
`endif
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Checks made at each negedge: protocol rules and the scoreboard
    task automatic observe();
        logic [31:0] e;
        chk("rden_when_empty", 256'(rdback_fifo_rden & rdback_fifo_empty), 256'(1'b0));
        chk("word_cnt", 256'(rdback_word_cnt), 256'(model_words));
        if (prev_stall) begin
            chk("stall_valid", 256'(out_valid), 256'(1'b1));
            chk("stall_data", 256'(out_data), 256'(prev_data));
            chk("stall_last", 256'(out_last), 256'(prev_last));
        end
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            chk("beat_pending", 256'(exp_beats.size() != 0), 256'(1'b1));
            if (exp_beats.size() != 0) begin
                e = exp_beats.pop_front();
                chk("beat_data", 256'(out_data), 256'(e));
            end
            chk("beat_last", 256'(out_last), 256'(beat_in_word == NC-1));
            beat_in_word++;
            if (beat_in_word == NC) begin
                beat_in_word = 0;
                model_words  = model_words + 32'd1;
            end
        end
        if (cyc < 64) begin
            rden_log[cyc]  = rdback_fifo_rden;
            valid_log[cyc] = out_valid;
        end
        prev_stall = out_valid & ~out_ready & rst_n;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    // One clock cycle: observe at the negedge, then model the FIFO after the
    // posedge. Read data appears in the cycle after rden.
    task automatic tick();
        logic         rd;
        logic [255:0] w;
        @(negedge clk);
        observe();
        rd = rdback_fifo_rden;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            rdback_fifo_rddata = w;
            for (int k = 0; k < NC; k++) exp_beats.push_back(host_beat(w[k*32 +: 32]));
        end
        rdback_fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic push_word(input logic [255:0] w);
        fifo_q.push_back(w);
        rdback_fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        for (int c = 0; c < 64; c++) begin
            rden_log[c]  = 1'b0;
            valid_log[c] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [4];
        logic [255:0] seq_w;
        logic [255:0] w;
        logic [31:0]  start_cnt;
        int           n_rden;
        int           first_valid;
        int           n_valid;
        bit           exp_v;

        for (int k = 0; k < NC; k++) seq_w[k*32 +: 32] = 32'h1000_0000 + 32'(k);

        vecs[0].word = seq_w;
        vecs[1].word = {32'hCAFE_F00D, 192'h0, 32'h1122_3344};
        vecs[2].word = {256{1'b1}};
        vecs[3].word = {32'h8000_0000, 192'h0, 32'h0000_0001};
`ifdef RDBACK_BYTE_SWAP_EN
        vecs[0].exp_first = 32'h0000_0010; vecs[0].exp_last = 32'h0700_0010;
        vecs[1].exp_first = 32'h4433_2211; vecs[1].exp_last = 32'h0DF0_FECA;
        vecs[2].exp_first = 32'hFFFF_FFFF; vecs[2].exp_last = 32'hFFFF_FFFF;
        vecs[3].exp_first = 32'h0100_0000; vecs[3].exp_last = 32'h0000_0080;
`else
        vecs[0].exp_first = 32'h1000_0000; vecs[0].exp_last = 32'h1000_0007;
        vecs[1].exp_first = 32'h1122_3344; vecs[1].exp_last = 32'hCAFE_F00D;
        vecs[2].exp_first = 32'hFFFF_FFFF; vecs[2].exp_last = 32'hFFFF_FFFF;
        vecs[3].exp_first = 32'h0000_0001; vecs[3].exp_last = 32'h8000_0000;
`endif

        // Reset held with the FIFO non-empty and out_ready high
        rst_n = 1'b0;
        out_ready = 1'b1;
        rdback_fifo_empty = 1'b1;
        rdback_fifo_rddata = 256'd0;
        push_word(seq_w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", 256'(out_valid), 256'(1'b0));
            chk("rst_last", 256'(out_last), 256'(1'b0));
            chk("rst_data", 256'(out_data), 256'(32'd0));
            chk("rst_rden", 256'(rdback_fifo_rden), 256'(1'b0));
            chk("rst_cnt", 256'(rdback_word_cnt), 256'(32'd0));
            @(posedge clk);
            #1;
        end

        // Single word right after reset is released
        rst_n = 1'b1;
        clear_logs();
        got_q.delete();
        cyc = 0;
        repeat (12) tick();
        n_rden = 0;
        n_valid = 0;
        first_valid = -1;
        for (int c = 0; c < 12; c++) begin
            if (rden_log[c]) n_rden++;
            if (valid_log[c]) n_valid++;
            if (valid_log[c] && first_valid < 0) first_valid = c;
        end
        chk("single_rden_first_cycle", 256'(rden_log[0]), 256'(1'b1));
        chk("single_rden_count", 256'(n_rden), 256'(1));
        chk("single_first_valid", 256'(first_valid), 256'(2));
        chk("single_valid_cycles", 256'(n_valid), 256'(8));
        chk("single_beats", 256'(got_q.size()), 256'(8));
        for (int k = 0; k < NC; k++)
            if (k < got_q.size()) chk("single_order", 256'(got_q[k]), 256'(host_beat(32'h1000_0000 + 32'(k))));
        chk("single_cnt", 256'(rdback_word_cnt), 256'(32'd1));
        chk("single_idle", 256'(out_valid), 256'(1'b0));

        // Table-driven words
        for (int v = 0; v < 4; v++) begin
            got_q.delete();
            start_cnt = model_words;
            push_word(vecs[v].word);
            repeat (12) tick();
            chk("vec_beats", 256'(got_q.size()), 256'(8));
            if (got_q.size() == 8) begin
                chk("vec_first", 256'(got_q[0]), 256'(vecs[v].exp_first));
                chk("vec_last", 256'(got_q[7]), 256'(vecs[v].exp_last));
            end
            chk("vec_cnt", 256'(rdback_word_cnt), 256'(start_cnt + 32'd1));
        end

        // Back-pressure: out_ready follows the pattern 1,0,0,1,...
        got_q.delete();
        push_word(seq_w);
        cyc = 0;
        for (int t = 0; t < 60 && got_q.size() < 8; t++) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();
        chk("bp_beats", 256'(got_q.size()), 256'(8));
        for (int k = 0; k < NC; k++)
            if (k < got_q.size()) chk("bp_order", 256'(got_q[k]), 256'(host_beat(32'h1000_0000 + 32'(k))));

        // Back-to-back: three words preloaded
        got_q.delete();
        start_cnt = model_words;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NC; k++) w[k*32 +: 32] = $urandom;
            push_word(w);
        end
        clear_logs();
        cyc = 0;
        repeat (30) tick();
        for (int c = 0; c < 30; c++) begin
            exp_v = 1'b0;
            for (int wi = 0; wi < 3; wi++)
                if (c >= 9*wi + 2 && c <= 9*wi + 9) exp_v = 1'b1;
            chk("b2b_rden", 256'(rden_log[c]), 256'(c == 0 || c == 9 || c == 18));
            chk("b2b_valid", 256'(valid_log[c]), 256'(exp_v));
        end
        chk("b2b_beats", 256'(got_q.size()), 256'(24));
        chk("b2b_cnt", 256'(rdback_word_cnt), 256'(start_cnt + 32'd3));

        // Mid-word reset after three accepted beats
        got_q.delete();
        push_word(seq_w);
        cyc = 0;
        repeat (5) tick();
        chk("mid_beats_before", 256'(got_q.size()), 256'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 256'(out_valid), 256'(1'b0));
        chk("mid_data", 256'(out_data), 256'(32'd0));
        chk("mid_last", 256'(out_last), 256'(1'b0));
        chk("mid_cnt", 256'(rdback_word_cnt), 256'(32'd0));
        chk("mid_rden", 256'(rdback_fifo_rden), 256'(1'b0));
        exp_beats.delete();
        beat_in_word = 0;
        model_words = 32'd0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        cyc = 0;
        repeat (6) tick();
        for (int c = 0; c < 6; c++) begin
            chk("post_rst_rden", 256'(rden_log[c]), 256'(1'b0));
            chk("post_rst_valid", 256'(valid_log[c]), 256'(1'b0));
        end
        chk("post_rst_cnt", 256'(rdback_word_cnt), 256'(32'd0));

        // Random traffic checked against the scoreboard
        for (int t = 0; t < 400; t++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0 && fifo_q.size() < 4) begin
                for (int k = 0; k < NC; k++) w[k*32 +: 32] = $urandom;
                push_word(w);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int t = 0; t < 300 && (fifo_q.size() != 0 || exp_beats.size() != 0 || out_valid); t++) tick();
        chk("rand_drained", 256'(fifo_q.size() + exp_beats.size()), 256'(0));
        chk("rand_idle", 256'(out_valid), 256'(1'b0));
        chk("rand_cnt", 256'(rdback_word_cnt), 256'(model_words));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
